// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Control FSM for a chain of cascaded 4-bit synchronous counters
//   (LS161a-style, W/4 stages, RCO rippled into the next stage's ENT).
//   It turns a START/STOP/HOLD command interface plus a period length
//   into the counters' D / LOAD_n / ENP / ENT / CLR_n pins. Periods can
//   be one-shot or auto-reload.
//
//   The counters are preloaded with RV = 2^W - len_r, so the last stage
//   raises RCO exactly len_r clocks after the load. That RCO marks the
//   end of a period.
//
//   Handshake: START, STOP and ERR are single-cycle pulses. START is
//   accepted only in IDLE, and is accepted only when LEN != 0. A rejected
//   START (LEN == 0) gives one ERR pulse on the following cycle. HOLD is
//   a level and freezes counting while it is high.
//
// Ports
//   CLK         clock, rising edge
//   CLR         synchronous active-high reset; also clears the counters
//   START       pulse: begin a period sequence (samples AUTO and LEN)
//   STOP        pulse: abort the sequence
//   HOLD        level: freeze counting
//   AUTO        1 = auto-reload, 0 = one-shot
//   LEN [W]     period length in clocks; 0 is illegal
//   RCO_IN      RCO of the last counter stage
//   CNT_D [W]   parallel-load value
//   CNT_LOAD_n  active-low synchronous load
//   CNT_ENP     count enable parallel, all stages
//   CNT_ENT     count enable trickle, first stage
//   CNT_CLR_n   active-low clear
//   BUSY        sequence in progress
//   TICK        one-cycle pulse per completed period
//   DONE        one-cycle pulse at one-shot completion
//   ERR         one-cycle pulse: START rejected because LEN == 0
//
//   W must be a multiple of 4.
module counter_sequencer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         START,
    input  logic         STOP,
    input  logic         HOLD,
    input  logic         AUTO,
    input  logic [W-1:0] LEN,
    input  logic         RCO_IN,
    output logic [W-1:0] CNT_D,
    output logic         CNT_LOAD_n,
    output logic         CNT_ENP,
    output logic         CNT_ENT,
    output logic         CNT_CLR_n,
    output logic         BUSY,
    output logic         TICK,
    output logic         DONE,
    output logic         ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CLEAR
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] len_r;
    logic         auto_r;
    logic         err_r;
    logic         done_r;
    logic [W-1:0] rv;
    logic         term;
    logic         accept;
    logic         err_set;
    logic         done_set;

    // Two's-complement negation gives (2^W - len_r) mod 2^W.
    assign rv = '0 - len_r;

    // End of a period: the chain shows all-ones and is actually counting.
    // STOP outranks a coincident period end.
    assign term     = (state == S_RUN) & RCO_IN & ~HOLD & ~STOP;
    assign accept   = (state == S_IDLE) & START & (LEN != '0);
    assign err_set  = (state == S_IDLE) & START & (LEN == '0);
    // This flag tells CLEAR whether it was entered by one-shot completion.
    assign done_set = term & ~auto_r;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= S_IDLE;
            len_r  <= '0;
            auto_r <= 1'b0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            err_r  <= err_set;
            done_r <= done_set;
            if (accept) begin
                len_r  <= LEN;
                auto_r <= AUTO;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        CNT_D      = '0;
        CNT_LOAD_n = 1'b1;
        CNT_ENP    = 1'b0;
        CNT_ENT    = 1'b0;
        CNT_CLR_n  = 1'b1;
        BUSY       = 1'b0;
        TICK       = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;

        if (CLR) begin
            // Clear the external counters in the same edge that resets the FSM.
            CNT_CLR_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ERR = err_r;
                    if (accept) begin
                        state_nx = S_LOAD;
                    end
                end
                S_LOAD: begin
                    CNT_D      = rv;
                    CNT_LOAD_n = 1'b0;
                    BUSY       = 1'b1;
                    state_nx   = STOP ? S_CLEAR : S_RUN;
                end
                S_RUN: begin
                    CNT_D   = rv;
                    CNT_ENT = 1'b1;
                    CNT_ENP = ~HOLD;
                    BUSY    = 1'b1;
                    TICK    = term;
                    // In auto mode, reload at the same edge where the chain would wrap.
                    CNT_LOAD_n = ~(term & auto_r);
                    if (STOP || done_set) begin
                        state_nx = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    CNT_CLR_n = 1'b0;
                    BUSY      = 1'b1;
                    DONE      = done_r;
                    state_nx  = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Drives counter_sequencer (W=8) with two LS161a-style 4-bit stages
//   cascaded through RCO -> ENT.
//
//   Every stimulus cycle, a behavioural model of the sequencer and counter
//   chain pushes the expected observation (outputs plus counter Q) into
//   exp_q. A separate monitor pops one entry for each observed cycle and
//   compares it.
module tb_counter_sequencer;

    localparam int W = 8;
    localparam logic [W-1:0] ALL_ONES = '1;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_RUN   = 2;
    localparam int P_CLEAR = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         clr = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         hold = 1'b0;
    logic         auto_i = 1'b0;
    logic [W-1:0] len = '0;

    logic         rco_in;
    logic [W-1:0] cnt_d;
    logic         cnt_load_n;
    logic         cnt_enp;
    logic         cnt_ent;
    logic         cnt_clr_n;
    logic         busy;
    logic         tick;
    logic         done;
    logic         err;

    counter_sequencer #(.W(W)) dut (
        .CLK        (clk),
        .CLR        (clr),
        .START      (start),
        .STOP       (stop),
        .HOLD       (hold),
        .AUTO       (auto_i),
        .LEN        (len),
        .RCO_IN     (rco_in),
        .CNT_D      (cnt_d),
        .CNT_LOAD_n (cnt_load_n),
        .CNT_ENP    (cnt_enp),
        .CNT_ENT    (cnt_ent),
        .CNT_CLR_n  (cnt_clr_n),
        .BUSY       (busy),
        .TICK       (tick),
        .DONE       (done),
        .ERR        (err)
    );

    // ---------------- two LS161a stages ----------------
    logic [3:0] q0 = 4'h0;
    logic [3:0] q1 = 4'h0;
    logic       rco0;
    logic       rco1;

    assign rco0   = (q0 == 4'hF) & cnt_ent;
    assign rco1   = (q1 == 4'hF) & rco0;
    assign rco_in = rco1;

    always @(posedge clk) begin
        if (!cnt_clr_n) begin
            q0 <= 4'h0;
            q1 <= 4'h0;
        end else if (!cnt_load_n) begin
            q0 <= cnt_d[3:0];
            q1 <= cnt_d[7:4];
        end else begin
            if (cnt_enp && cnt_ent) q0 <= q0 + 4'h1;
            if (cnt_enp && rco0)    q1 <= q1 + 4'h1;
        end
    end

    // ---------------- scoreboard ----------------
    // Observation layout: {d[8], q[8], load_n, enp, ent, clr_n, busy, tick, done, err}
    localparam int OW = 2 * W + 8;
    logic [OW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model state
    int           m_ph   = P_IDLE;
    logic [W-1:0] m_len  = '0;
    logic         m_auto = 1'b0;
    logic         m_err  = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_q    = '0;

    task automatic step(input logic c, input logic s, input logic p,
                        input logic h, input logic a, input logic [W-1:0] l);
        logic [W-1:0] e_d;
        logic         e_ln, e_enp, e_ent, e_cn, e_busy, e_tick, e_done, e_err;
        logic [W-1:0] rv;
        logic         wrap;
        @(negedge clk);
        clr = c; start = s; stop = p; hold = h; auto_i = a; len = l;
        cyc++;
        #1;
        rv     = W'((1 << W) - int'(m_len));
        wrap   = (m_q == ALL_ONES) && !h && !p;
        e_d    = '0; e_ln = 1'b1; e_enp = 1'b0; e_ent = 1'b0; e_cn = 1'b1;
        e_busy = 1'b0; e_tick = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (c) begin
            e_cn = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE:  e_err = m_err;
                P_LOAD:  begin e_d = rv; e_ln = 1'b0; e_busy = 1'b1; end
                P_RUN:   begin
                    e_d = rv; e_ent = 1'b1; e_enp = !h; e_busy = 1'b1;
                    e_tick = wrap; e_ln = !(wrap && m_auto);
                end
                default: begin e_cn = 1'b0; e_busy = 1'b1; e_done = m_done; end
            endcase
        end
        exp_q.push_back({e_d, m_q, e_ln, e_enp, e_ent, e_cn, e_busy, e_tick, e_done, e_err});

        // Advance the model to the state after this edge.
        if (c) begin
            m_ph = P_IDLE; m_len = '0; m_auto = 1'b0; m_err = 1'b0; m_done = 1'b0; m_q = '0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    m_err  = s && (l == '0);
                    m_done = 1'b0;
                    if (s && l != '0) begin
                        m_len = l; m_auto = a; m_ph = P_LOAD;
                    end
                end
                P_LOAD: begin
                    m_q = rv; m_err = 1'b0; m_done = 1'b0;
                    m_ph = p ? P_CLEAR : P_RUN;
                end
                P_RUN: begin
                    m_err = 1'b0;
                    m_done = wrap && !m_auto;
                    if (wrap && m_auto) m_q = rv;
                    else if (!h)        m_q = m_q + 1'b1;
                    if (p || (wrap && !m_auto)) m_ph = P_CLEAR;
                end
                default: begin
                    m_q = '0; m_err = 1'b0; m_done = 1'b0; m_ph = P_IDLE;
                end
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic go(input logic a, input logic [W-1:0] l);
        step(1'b0, 1'b1, 1'b0, 1'b0, a, l);
    endtask

    task automatic halt();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [OW-1:0] e;
        logic [OW-1:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {cnt_d, q1, q0, cnt_load_n, cnt_enp, cnt_ent, cnt_clr_n,
                       busy, tick, done, err};
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL cycle %0d outputs: got d=%h q=%h ln/enp/ent/clrn/busy/tick/done/err=%b, want d=%h q=%h bits=%b",
                             cyc, act[OW-1 -: W], act[OW-W-1 -: W], act[7:0],
                             e[OW-1 -: W], e[OW-W-1 -: W], e[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(2);

        // one-shot LEN=5
        go(1'b0, 8'd5);
        idle(9);

        // auto LEN=3, then STOP
        go(1'b1, 8'd3);
        idle(10);
        halt();
        idle(2);

        // auto LEN=4, HOLD two cycles while Q=FE
        go(1'b1, 8'd4);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(9);
        halt();
        idle(2);

        // STOP in the cycle Q=FF, one-shot LEN=5
        go(1'b0, 8'd5);
        idle(5);
        halt();
        idle(3);

        // LEN=0 rejected, then LEN=1 auto
        go(1'b1, 8'd0);
        idle(2);
        go(1'b1, 8'd1);
        idle(5);
        halt();
        idle(2);

        // START while busy is ignored; STOP in LOAD
        go(1'b0, 8'd6);
        go(1'b1, 8'd2);
        idle(8);
        go(1'b0, 8'd3);
        halt();
        idle(3);

        // CLR mid-RUN at Q=FC, then a LEN=2 one-shot
        go(1'b1, 8'd8);
        idle(5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(1);
        go(1'b0, 8'd2);
        idle(5);

        // longest period: RV = 1
        go(1'b0, 8'd255);
        idle(260);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] rl;
            rl = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 12));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 1) == 1, rl);
        end
        idle(2);

        @(negedge clk);
        #4;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
